// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared external ALU.
// Only one operation is in flight at a time; ties go to whichever requester was not served last.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_con,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_con,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_out,
  output logic             resp_zero,
  output logic [3:0]       alu_con,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             last_grant_r;
  logic             gnt_r;
  logic             grant_s;
  logic             idle_s;
  logic             hs_s;
  logic             resp_take_s;
  logic [3:0]       con_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] resp_out_r;
  logic             resp_zero_r;

  // Arbitration: a tie goes to the requester not granted last time
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // rst_n gating keeps the ready outputs low while reset is held
  assign idle_s      = (state_r == IDLE) && rst_n;
  assign req0_ready  = idle_s && req0_valid && !grant_s;
  assign req1_ready  = idle_s && req1_valid && grant_s;
  assign hs_s        = req0_ready || req1_ready;
  assign resp_take_s = gnt_r ? resp1_ready : resp0_ready;

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (resp_take_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latch on handshake, result capture at the end of EXEC, grant history on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
      gnt_r        <= 1'b0;
      con_r        <= 4'd0;
      a_r          <= '0;
      b_r          <= '0;
      resp_out_r   <= '0;
      resp_zero_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            gnt_r <= grant_s;
            con_r <= grant_s ? req1_con : req0_con;
            a_r   <= grant_s ? req1_a   : req0_a;
            b_r   <= grant_s ? req1_b   : req0_b;
          end
        end
        EXEC: begin
          resp_out_r  <= alu_out;
          resp_zero_r <= alu_zero;
        end
        RESP: begin
          if (resp_take_s) begin
            last_grant_r <= gnt_r;
          end
        end
        default: begin
          gnt_r <= gnt_r;
        end
      endcase
    end
  end

  // ALU port is driven only while the operation executes
  always_comb begin
    alu_con = 4'd0;
    alu_a   = '0;
    alu_b   = '0;
    if (state_r == EXEC) begin
      alu_con = con_r;
      alu_a   = a_r;
      alu_b   = b_r;
    end else begin
      alu_con = 4'd0;
      alu_a   = '0;
      alu_b   = '0;
    end
  end

  assign resp0_valid = (state_r == RESP) && !gnt_r;
  assign resp1_valid = (state_r == RESP) && gnt_r;
  assign resp_out    = resp_out_r;
  assign resp_zero   = resp_zero_r;
  assign busy        = (state_r != IDLE);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width shared with the ALU.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_con  input  4  requester N ALU control code (0010 add, 0110 sub, 0001 or, 0000 and, 0111 slt).
REQ-007 reqN_a, reqN_b  input  WIDTH  requester N operands.
REQ-008 respN_valid  output  1  result available for requester N.
REQ-009 respN_ready  input  1  requester N takes result this cycle.
REQ-010 resp_out  output  WIDTH  result, shared by both requesters; qualified by respN_valid.
REQ-011 resp_zero  output  1  ALU zero flag captured with resp_out.
REQ-012 alu_con  output  4  control code to the external shared ALU.
REQ-013 alu_a, alu_b  output  WIDTH  operands to the shared ALU.
REQ-014 alu_out  input  WIDTH  combinational ALU result.
REQ-015 alu_zero  input  1  combinational ALU zero flag.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 States: IDLE, EXEC, RESP; one operation in flight at a time.
REQ-018 IDLE: if exactly one reqN_valid, grant N; if both, grant the requester not granted last (last_grant pointer).
REQ-019 reqN_ready is high only in IDLE, only for the granted N, and only while reqN_valid is high; combinational from state, valid and last_grant.
REQ-020 On handshake (reqN_valid & reqN_ready): con/a/b latched into operand registers, grant index latched, go to EXEC.
REQ-021 EXEC: alu_con/alu_a/alu_b driven from operand registers; alu_out/alu_zero captured into resp_out/resp_zero at cycle end; go to RESP.
REQ-022 RESP: respN_valid high for the granted N only; resp_out/resp_zero held stable; stays in RESP until respN_ready, then IDLE and last_grant <= N.
REQ-023 Latency: handshake in cycle T -> respN_valid high from cycle T+2; minimum issue interval 3 cycles.
REQ-024 No request accepted while busy; reqN_ready low in EXEC and RESP regardless of valid.
REQ-025 Outside EXEC, alu_con/alu_a/alu_b driven to 0.
REQ-026 Control codes passed unchanged; undefined codes yield whatever the ALU returns (0, zero=1) with no error.
REQ-027 Requester dropping reqN_valid before handshake: no grant is recorded, last_grant unchanged.
REQ-028 respN_ready asserted while respN_valid low has no effect.

Reset
REQ-029 rst_n low asynchronously forces IDLE; last_grant=1 (requester 0 wins first tie); operand regs, resp_out=0, resp_zero=0.
REQ-030 During reset all respN_valid, reqN_ready, busy = 0; alu_* outputs = 0.
REQ-031 Reset in EXEC or RESP discards the operation; no response is ever issued for it.

Verification
REQ-032 After reset, req0 add a=5 b=7 -> req0_ready same cycle, resp0_valid 2 cycles later, resp_out=12, resp_zero=0.
REQ-033 Both valid in same cycle after reset (req0 sub 9-9, req1 or 0xF0|0x0F) -> req0 served first (resp_out=0, zero=1), then req1 (resp_out=0xFF, zero=0).
REQ-034 Both held valid continuously for 4 operations -> grants alternate 0,1,0,1; each response 3 cycles apart when respN_ready held high.
REQ-035 req1 slt a=3 b=8 with resp1_ready low for 5 cycles -> resp1_valid and resp_out=1 held stable 5 cycles, busy high, req0_ready stays low.
REQ-036 Assert rst_n low mid-EXEC -> respN_valid never asserts for that op, busy=0 immediately, next request granted normally with req0 priority.
REQ-037 Unknown code 4'b1111 a=1 b=1 -> resp_out=0, resp_zero=1, latency unchanged.
